spi_ram_master: RTL and testbench

SPI_RAM_MASTER -- requirements
Module: spi_ram_master

---
 rtl/spi_ram_master.sv | 172 +++++++++++++++++
 tb/tb_spi_ram_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_master.sv
// SPI master for a serial RAM: each read or write is two 11-bit command frames.
// A read also collects 8 MISO bits after a programmable wait.
module spi_ram_master #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned GAP    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       busy,
    output logic       ss_n,
    output logic       MOSI,
    input  logic       MISO
);
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned WW = 10;

    localparam logic [CW-1:0] LAST_BIT  = CW'(WW);
    localparam logic [CW-1:0] LAST_RX   = CW'(DW - 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] LAST_GAP  = CW'(GAP - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RECV = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]    state, state_d;
    logic          f, f_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          rd_q, rd_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] shreg, shreg_d;
    logic [DW-1:0] rdata_d;
    logic          rvalid_d;
    logic [WW-1:0] word_d;
    logic [CW-1:0] bit_idx;
    logic          ss_n_d;
    logic          mosi_d;
    logic          ready_d;

    // Next state, plus the registered line/status values derived from it
    always_comb begin
        state_d  = state;
        f_d      = f;
        cnt_d    = cnt;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        shreg_d  = shreg;
        rdata_d  = rdata;
        rvalid_d = 1'b0;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_SEND;
                    f_d     = 1'b0;
                    cnt_d   = '0;
                    rd_d    = req_rd;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            S_SEND: begin
                if (cnt == LAST_BIT) begin
                    cnt_d = '0;
                    if (rd_q && f) begin
                        state_d = (RD_LAT == 0) ? S_RECV : S_WAIT;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_WAIT: begin
                if (cnt == LAST_WAIT) begin
                    cnt_d   = '0;
                    state_d = S_RECV;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_RECV: begin
                shreg_d = {shreg[DW-2:0], MISO};
                if (cnt == LAST_RX) begin
                    cnt_d    = '0;
                    state_d  = S_GAP;
                    rdata_d  = shreg_d;
                    rvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == LAST_GAP) begin
                    cnt_d = '0;
                    if (!f) begin
                        state_d = S_SEND;
                        f_d     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Command bit 9 goes out twice: once as the select bit, once as the word MSB
        word_d  = {rd_d, f_d, f_d ? (rd_d ? 8'h00 : wdata_d) : addr_d};
        bit_idx = (cnt_d == '0) ? CW'(WW - 1) : (CW'(WW) - cnt_d);
        ss_n_d  = !((state_d == S_SEND) || (state_d == S_WAIT) || (state_d == S_RECV));
        mosi_d  = (state_d == S_SEND) ? word_d[bit_idx] : 1'b0;
        ready_d = (state_d == S_IDLE);
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            f     <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            f     <= f_d;
            cnt   <= cnt_d;
        end
    end

    // Latched request, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            shreg       <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            ss_n        <= 1'b1;
            MOSI        <= 1'b0;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            shreg       <= shreg_d;
            rdata       <= rdata_d;
            rdata_valid <= rvalid_d;
            ss_n        <= ss_n_d;
            MOSI        <= mosi_d;
            req_ready   <= ready_d;
            busy        <= !ready_d;
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master: three configurations, a MISO slave model and per-cycle line traces.
module tb_spi_ram_master;
    localparam int NI   = 3;
    localparam int TMAX = 4096;

    typedef struct {
        int          g;
        bit          rd;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  sd;
        logic [10:0] f0;
        logic [10:0] f1;
        int          gap_hi;
        int          rv_off;
        int          rdy_off;
        logic [7:0]  rdata_exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid   [NI];
    logic       req_ready   [NI];
    logic       req_rd      [NI];
    logic [7:0] req_addr    [NI];
    logic [7:0] req_wdata   [NI];
    logic [7:0] rdata       [NI];
    logic       rdata_valid [NI];
    logic       busy        [NI];
    logic       ss_n        [NI];
    logic       mosi        [NI];
    logic       miso        [NI];
    logic [7:0] sdata       [NI];

    logic tr_ssn  [NI][TMAX];
    logic tr_mosi [NI][TMAX];
    logic tr_rdy  [NI][TMAX];
    logic tr_rv   [NI][TMAX];
    int   lowcnt  [NI];

    int cyc = 0;
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int g);
        return (g == 1) ? 0 : ((g == 2) ? 3 : 1);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        spi_ram_master #(
            .RD_LAT((g == 1) ? 0 : ((g == 2) ? 3 : 1)),
            .GAP   ((g == 0) ? 1 : 4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_rd     (req_rd[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .rdata      (rdata[g]),
            .rdata_valid(rdata_valid[g]),
            .busy       (busy[g]),
            .ss_n       (ss_n[g]),
            .MOSI       (mosi[g]),
            .MISO       (miso[g])
        );
    end

    // Trace recorder and slave: data bits only inside the capture window, noise elsewhere
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (cyc < TMAX) begin
                tr_ssn[g][cyc]  = ss_n[g];
                tr_mosi[g][cyc] = mosi[g];
                tr_rdy[g][cyc]  = req_ready[g];
                tr_rv[g][cyc]   = rdata_valid[g];
            end
            if (ss_n[g] === 1'b0) begin
                if (lowcnt[g] >= 11 + lat_of(g) && lowcnt[g] < 19 + lat_of(g))
                    miso[g] = sdata[g][7 - (lowcnt[g] - 11 - lat_of(g))];
                else
                    miso[g] = 1'($urandom);
                lowcnt[g]++;
            end else begin
                lowcnt[g] = 0;
                miso[g]   = 1'($urandom);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [10:0] frame_at(input int g, input int s);
        logic [10:0] r;
        r = '0;
        for (int k = 0; k < 11; k++)
            if (s + k < TMAX) r[10-k] = tr_mosi[g][s+k];
        return r;
    endfunction

    task automatic do_txn(input int g, input bit rd, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] sd, output int t);
        sdata[g]     = sd;
        req_rd[g]    = rd;
        req_addr[g]  = addr;
        req_wdata[g] = wdata;
        req_valid[g] = 1'b1;
        t = -1;
        for (int i = 0; i < 100; i++) begin
            if (req_ready[g] === 1'b1) begin
                t = cyc;
                break;
            end
            tick();
        end
        tick();
        req_valid[g] = 1'b0;
        req_rd[g]    = 1'($urandom);
        req_addr[g]  = 8'($urandom);
        req_wdata[g] = 8'($urandom);
        if (t < 0) begin
            nchk++;
            nerr++;
            $display("FAIL accept_timeout: inst %0d never ready", g);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int t, s1, s1_end, first_rdy, first_rv, nrv, bad, bad_cyc;
        logic exp_ssn, exp_mosi, in_bits;
        do_txn(v.g, v.rd, v.addr, v.wdata, v.sd, t);
        if (t < 0) return;
        while (cyc <= t + v.rdy_off + 2) tick();

        s1     = t + 12 + v.gap_hi;
        s1_end = s1 + 10 + (v.rd ? lat_of(v.g) + 8 : 0);
        chk({tag, "_f0"}, 32'(frame_at(v.g, t + 1)), 32'(v.f0));
        chk({tag, "_f1"}, 32'(frame_at(v.g, s1)), 32'(v.f1));

        bad = 0;
        bad_cyc = -1;
        for (int c = t + 1; c <= t + v.rdy_off; c++) begin
            in_bits  = (c <= t + 11) || (c >= s1 && c <= s1 + 10);
            exp_ssn  = !((c <= t + 11) || (c >= s1 && c <= s1_end));
            exp_mosi = 1'b0;
            if (tr_ssn[v.g][c] !== exp_ssn || (!in_bits && tr_mosi[v.g][c] !== exp_mosi)) begin
                bad++;
                if (bad_cyc < 0) bad_cyc = c - t;
            end
        end
        chk({tag, "_line_profile_first_bad_offset"}, 32'(bad_cyc), 32'(-1));

        first_rdy = -1;
        for (int c = t + 1; c <= t + v.rdy_off + 2; c++)
            if (first_rdy < 0 && tr_rdy[v.g][c] === 1'b1) first_rdy = c - t;
        chk({tag, "_ready_offset"}, 32'(first_rdy), 32'(v.rdy_off));

        first_rv = 0;
        nrv = 0;
        for (int c = t + 1; c <= t + v.rdy_off + 2; c++)
            if (tr_rv[v.g][c] === 1'b1) begin
                nrv++;
                if (first_rv == 0) first_rv = c - t;
            end
        chk({tag, "_rvalid_offset"}, 32'(first_rv), 32'(v.rv_off));
        chk({tag, "_rvalid_count"}, 32'(nrv), 32'((v.rv_off != 0) ? 1 : 0));
        chk({tag, "_rdata"}, 32'(rdata[v.g]), 32'(v.rdata_exp));
    endtask

    initial begin
        vec_t vecs[8];
        vec_t wr_after_rst;
        int acc[4];
        int idx, t, nrv;
        logic [7:0]  b2b_addr [4];
        logic        b2b_rd   [4];
        logic [10:0] b2b_f0   [4];

        vecs[0] = '{0, 1'b0, 8'h3C, 8'hA5, 8'h00, 11'b000_0011_1100, 11'b001_1010_0101, 1, 0,  25, 8'h00};
        vecs[1] = '{0, 1'b1, 8'h7F, 8'h00, 8'hC3, 11'b110_0111_1111, 11'b111_0000_0000, 1, 33, 34, 8'hC3};
        vecs[2] = '{0, 1'b0, 8'hFF, 8'h00, 8'h00, 11'b000_1111_1111, 11'b001_0000_0000, 1, 0,  25, 8'hC3};
        vecs[3] = '{0, 1'b1, 8'h00, 8'hFF, 8'h00, 11'b110_0000_0000, 11'b111_0000_0000, 1, 33, 34, 8'h00};
        vecs[4] = '{0, 1'b1, 8'hA5, 8'h00, 8'h81, 11'b110_1010_0101, 11'b111_0000_0000, 1, 33, 34, 8'h81};
        vecs[5] = '{1, 1'b1, 8'h12, 8'h00, 8'h5A, 11'b110_0001_0010, 11'b111_0000_0000, 4, 35, 39, 8'h5A};
        vecs[6] = '{2, 1'b1, 8'h34, 8'h00, 8'h5A, 11'b110_0011_0100, 11'b111_0000_0000, 4, 38, 42, 8'h5A};
        vecs[7] = '{1, 1'b0, 8'h55, 8'h0F, 8'h00, 11'b000_0101_0101, 11'b001_0000_1111, 4, 0,  31, 8'h5A};
        wr_after_rst = '{0, 1'b0, 8'h66, 8'h99, 8'h00, 11'b000_0110_0110, 11'b001_1001_1001, 1, 0, 25, 8'h00};

        b2b_addr = '{8'h10, 8'h20, 8'h30, 8'h40};
        b2b_rd   = '{1'b0, 1'b1, 1'b0, 1'b1};
        b2b_f0   = '{11'b000_0001_0000, 11'b110_0010_0000, 11'b000_0011_0000, 11'b110_0100_0000};

        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            req_valid[g] = 1'b0;
            req_rd[g]    = 1'b0;
            req_addr[g]  = 8'h00;
            req_wdata[g] = 8'h00;
            sdata[g]     = 8'h00;
            lowcnt[g]    = 0;
        end
        repeat (3) tick();
        rst = 1'b0;

        chk("reset_ss_n", 32'(ss_n[0]), 32'd1);
        chk("reset_mosi", 32'(mosi[0]), 32'd0);
        chk("reset_rdata", 32'(rdata[0]), 32'h00);
        chk("reset_rvalid", 32'(rdata_valid[0]), 32'd0);
        chk("reset_busy", 32'(busy[0]), 32'd0);
        chk("reset_ready", 32'(req_ready[0]), 32'd1);
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // req_valid held high across alternating write/read requests
        sdata[0] = 8'h96;
        idx = 0;
        req_valid[0] = 1'b1;
        req_rd[0] = b2b_rd[0];
        req_addr[0] = b2b_addr[0];
        req_wdata[0] = 8'hE1;
        for (int i = 0; i < 200 && idx < 4; i++) begin
            if (req_ready[0] === 1'b1) begin
                acc[idx] = cyc;
                idx++;
            end
            tick();
            if (idx < 4) begin
                req_rd[0] = b2b_rd[idx];
                req_addr[0] = b2b_addr[idx];
            end else begin
                req_valid[0] = 1'b0;
            end
        end
        req_valid[0] = 1'b0;
        chk("b2b_accept_count", 32'(idx), 32'd4);
        if (idx == 4) begin
            while (cyc <= acc[3] + 36) tick();
            chk("b2b_delta_w", 32'(acc[1] - acc[0]), 32'd25);
            chk("b2b_delta_r", 32'(acc[2] - acc[1]), 32'd34);
            chk("b2b_delta_w2", 32'(acc[3] - acc[2]), 32'd25);
            for (int k = 0; k < 4; k++)
                chk($sformatf("b2b_f0_%0d", k), 32'(frame_at(0, acc[k] + 1)), 32'(b2b_f0[k]));
            for (int k = 1; k < 4; k++)
                chk($sformatf("b2b_high_run_%0d", k),
                    32'({tr_ssn[0][acc[k]-2], tr_ssn[0][acc[k]-1], tr_ssn[0][acc[k]], tr_ssn[0][acc[k]+1]}),
                    32'(4'b0110));
            nrv = 0;
            for (int c = acc[0]; c <= acc[3] + 36; c++) if (tr_rv[0][c] === 1'b1) nrv++;
            chk("b2b_rvalid_count", 32'(nrv), 32'd2);
            chk("b2b_rdata", 32'(rdata[0]), 32'h96);
        end

        // Reset during frame 1 of a read
        do_txn(0, 1'b1, 8'h7F, 8'h00, 8'hC3, t);
        if (t >= 0) begin
            while (cyc < t + 18) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("midrst_ss_n", 32'(ss_n[0]), 32'd1);
            chk("midrst_busy", 32'(busy[0]), 32'd0);
            chk("midrst_ready", 32'(req_ready[0]), 32'd1);
            chk("midrst_rdata", 32'(rdata[0]), 32'h00);
            repeat (30) tick();
            nrv = 0;
            for (int c = t + 1; c < cyc; c++) if (tr_rv[0][c] === 1'b1) nrv++;
            chk("midrst_no_rvalid", 32'(nrv), 32'd0);
            run_vec(wr_after_rst, "post_rst_wr");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
